// File: rtl/sha1_pkg.sv
// Shared constants and FSM state type for the SHA-1 round scheduler.
package sha1_pkg;
    localparam int DATA_W    = 32;
    localparam int WORDS     = 16;
    localparam int ROUNDS    = 80;
    localparam int PHASE_LEN = 20;
    localparam int LAST_TAP  = 75;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Last round of phases 0..2; the final phase boundary is handled by the r=79 wrap.
    function automatic logic is_phase_edge(input logic [6:0] r);
        return (r == 7'(PHASE_LEN - 1)) || (r == 7'(2 * PHASE_LEN - 1)) ||
               (r == 7'(3 * PHASE_LEN - 1));
    endfunction
endpackage

// File: rtl/sha1_block_buf.sv
// Ping-pong 16-word message buffer: fills one bank from the input stream while the other issues.
// Exports fill_partial only when SHA1_SCHED_PERF_EN is defined.
module sha1_block_buf
    import sha1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rd_en,
    input  logic [3:0]        rd_idx,
    output logic [DATA_W-1:0] din,
    output logic              issue_full
`ifdef SHA1_SCHED_PERF_EN
    ,
    output logic              fill_partial
`endif
);
    logic [DATA_W-1:0] mem [0:2*WORDS-1];
    logic [1:0]        full;
    logic              fill_bank;
    logic              issue_bank;
    logic [3:0]        fill_idx;
    logic              wr;

    assign in_ready   = !full[fill_bank];
    assign wr         = in_valid && in_ready;
    assign issue_full = full[issue_bank];
`ifdef SHA1_SCHED_PERF_EN
    assign fill_partial = (fill_idx != 4'd0);
`endif

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[{fill_bank, fill_idx}] <= in_data;
        end
    end

    // Fill and issue banks never coincide while both sides are active, so the
    // set and clear of full[] below always target different bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full       <= 2'b00;
            fill_bank  <= 1'b0;
            issue_bank <= 1'b0;
            fill_idx   <= 4'd0;
            din        <= '0;
        end else begin
            if (wr) begin
                fill_idx <= fill_idx + 4'd1;
                if (fill_idx == 4'(WORDS - 1)) begin
                    full[fill_bank] <= 1'b1;
                    fill_bank       <= ~fill_bank;
                end
            end
            if (rd_en) begin
                din <= mem[{issue_bank, rd_idx}];
                if (rd_idx == 4'(WORDS - 1)) begin
                    full[issue_bank] <= 1'b0;
                    issue_bank       <= ~issue_bank;
                end
            end
        end
    end
endmodule

// File: rtl/sha1_sched.sv
// SHA-1 80-round slot scheduler: FSM, round counter, load/phase decode and A-tap drain pipe.
// Optional SHA1_SCHED_PERF_EN adds perf_blocks/perf_idle counters.
module sha1_sched
    import sha1_pkg::*;
#(
    parameter int A_LAT = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              load6,
    output logic              phase_advance7,
    output logic [DATA_W-1:0] din,
    output logic              a_valid,
    output logic [2:0]        a_word,
    output logic              busy
`ifdef SHA1_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_blocks,
    output logic [31:0]       perf_idle
`endif
);
    state_t     state, state_nxt;
    logic [6:0] r, r_nxt;
    logic       issue_full;
    logic       run;
    logic       tag_in;
    logic [2:0] word_in;

    logic [A_LAT-1:0] vld_p;
    logic [A_LAT-1:0] tag_p;
    logic [2:0]       word_p [A_LAT];

`ifdef SHA1_SCHED_PERF_EN
    logic fill_partial;
`endif

    sha1_block_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_en      (load6),
        .rd_idx     (r[3:0]),
        .din        (din),
        .issue_full (issue_full)
`ifdef SHA1_SCHED_PERF_EN
        ,
        .fill_partial (fill_partial)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            r     <= '0;
        end else begin
            state <= state_nxt;
            r     <= r_nxt;
        end
    end

    // issue_full already points at the next bank by r=79 (the bank swaps after word 15 is read).
    always_comb begin
        state_nxt      = state;
        r_nxt          = r;
        phase_advance7 = 1'b0;
        load6          = 1'b0;
        case (state)
            IDLE: begin
                if (issue_full) begin
                    phase_advance7 = 1'b1;
                    state_nxt      = RUN;
                    r_nxt          = '0;
                end
            end
            RUN: begin
                load6 = (r < 7'(WORDS));
                if (is_phase_edge(r)) begin
                    phase_advance7 = 1'b1;
                end
                if (r == 7'(ROUNDS - 1)) begin
                    r_nxt = '0;
                    if (issue_full) begin
                        phase_advance7 = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    r_nxt = r + 7'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign run     = (state == RUN);
    assign tag_in  = run && (r >= 7'(LAST_TAP));
    assign word_in = 3'(r - 7'(LAST_TAP));

    // Drain pipe stage 0 captures the current round; stage A_LAT-1 lines up with cycle.A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            tag_p <= '0;
        end else begin
            vld_p[0] <= run;
            tag_p[0] <= tag_in;
            for (int i = 1; i < A_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        word_p[0] <= word_in;
        for (int i = 1; i < A_LAT; i++) begin
            word_p[i] <= word_p[i-1];
        end
    end

    assign a_valid = tag_p[A_LAT-1];
    assign a_word  = a_valid ? word_p[A_LAT-1] : 3'd0;
    assign busy    = run || (|vld_p);

`ifdef SHA1_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_blocks <= '0;
            perf_idle   <= '0;
        end else begin
            if (a_valid && (a_word == 3'd4)) begin
                perf_blocks <= perf_blocks + 32'd1;
            end
            if ((state == IDLE) && fill_partial) begin
                perf_idle <= perf_idle + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sha1_sched.sv
// Directed self-checking bench for sha1_sched: expected timing derived from block start cycles t0.
module tb_sha1_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, load6, phase_advance7, a_valid, busy;
    logic [31:0] din;
    logic [2:0]  a_word;
`ifdef SHA1_SCHED_PERF_EN
    logic [31:0] perf_blocks, perf_idle;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc [128];

    typedef struct {
        bit          pa;
        bit          ld;
        bit          dv;
        logic [31:0] dw;
        bit          av;
        logic [2:0]  aw;
        bit          busy;
    } exp_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha1_sched #(.A_LAT(7)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .load6          (load6),
        .phase_advance7 (phase_advance7),
        .din            (din),
        .a_valid        (a_valid),
        .a_word         (a_word),
        .busy           (busy)
`ifdef SHA1_SCHED_PERF_EN
        ,
        .perf_blocks    (perf_blocks),
        .perf_idle      (perf_idle)
`endif
    );

    function automatic logic [31:0] word(input int n);
        return {8'h5A, 8'(n), 8'(n * 3 + 1), 8'(~n)};
    endfunction

    // Expected outputs at relative cycle rc for blocks starting (load6 round 0) at t0s[b].
    function automatic exp_t model(input int rc, input int nb, input int t0s[3], input int wb[3]);
        exp_t e;
        e = '{pa: 0, ld: 0, dv: 0, dw: '0, av: 0, aw: '0, busy: 0};
        for (int b = 0; b < nb; b++) begin
            int t;
            t = t0s[b];
            if (rc == t - 1 || rc == t + 19 || rc == t + 39 || rc == t + 59) e.pa = 1;
            if (rc >= t && rc < t + 16) e.ld = 1;
            if (rc >= t + 1 && rc <= t + 16) begin
                e.dv = 1;
                e.dw = word(wb[b] + rc - t - 1);
            end
            if (rc >= t + 82 && rc <= t + 86) begin
                e.av = 1;
                e.aw = 3'(rc - t - 82);
            end
            if (rc >= t && rc <= t + 86) e.busy = 1;
        end
        return e;
    endfunction

    task automatic apply_reset(output int base);
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic feed(input int base, input int first, input int count, input int start_rc);
        int n;
        int rc;
        bit ok;
        n = first;
        while (cyc - base < start_rc) begin @(posedge clk); #1; end
        while (n < first + count) begin
            if (cyc - base > start_rc + 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL feed_timeout: word %0d still not accepted, required acceptance", n);
                break;
            end
            in_valid = 1'b1;
            in_data  = word(n);
            ok = in_ready;
            rc = cyc - base;
            @(posedge clk); #1;
            if (ok) begin
                acc_cyc[n] = rc;
                n++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        rst_n    = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (load6 !== 1'b0) begin n_fail++; $display("FAIL reset_load6 got %b want 0", load6); end
        n_checks++; if (phase_advance7 !== 1'b0) begin n_fail++; $display("FAIL reset_pa7 got %b want 0", phase_advance7); end
        n_checks++; if (din !== 32'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", din); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got %b want 0", a_valid); end
        n_checks++; if (a_word !== 3'd0) begin n_fail++; $display("FAIL reset_a_word got %0d want 0", a_word); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        in_valid = 1'b0;
        apply_reset(base);
    endtask

    task automatic test_single_block();
        int base;
        int t0s[3];
        int wb[3];
        exp_t e;
        logic [4:0] got, want;
        t0s = '{17, 0, 0};
        wb  = '{0, 0, 0};
        apply_reset(base);
        fork
            feed(base, 0, 16, 0);
            for (int rc = 0; rc < 110; rc++) begin
                e = model(rc, 1, t0s, wb);
                got  = {phase_advance7, load6, a_valid, busy, in_ready};
                want = {e.pa, e.ld, e.av, e.busy, 1'b1};
                n_checks++; if (got !== want) begin n_fail++; $display("FAIL single_ctrl rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                if (e.dv) begin n_checks++; if (din !== e.dw) begin n_fail++; $display("FAIL single_din rc=%0d got %h want %h", rc, din, e.dw); end end
                if (e.av) begin n_checks++; if (a_word !== e.aw) begin n_fail++; $display("FAIL single_a_word rc=%0d got %0d want %0d", rc, a_word, e.aw); end end
                @(posedge clk); #1;
            end
        join
    endtask

    task automatic test_back_to_back();
        int base;
        int t0s[3];
        int wb[3];
        exp_t e;
        logic [4:0] got, want;
        t0s = '{17, 97, 0};
        wb  = '{0, 16, 0};
        apply_reset(base);
        fork
            feed(base, 0, 32, 0);
            for (int rc = 0; rc < 190; rc++) begin
                e = model(rc, 2, t0s, wb);
                got  = {phase_advance7, load6, a_valid, busy, in_ready};
                want = {e.pa, e.ld, e.av, e.busy, 1'(rc != 32)};
                n_checks++; if (got !== want) begin n_fail++; $display("FAIL b2b_ctrl rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                if (e.dv) begin n_checks++; if (din !== e.dw) begin n_fail++; $display("FAIL b2b_din rc=%0d got %h want %h", rc, din, e.dw); end end
                if (e.av) begin n_checks++; if (a_word !== e.aw) begin n_fail++; $display("FAIL b2b_a_word rc=%0d got %0d want %0d", rc, a_word, e.aw); end end
                @(posedge clk); #1;
            end
        join
    endtask

    task automatic test_backpressure();
        int base;
        int t0s[3];
        int wb[3];
        exp_t e;
        logic [4:0] got, want;
        bit ir;
        t0s = '{17, 97, 177};
        wb  = '{0, 16, 32};
        apply_reset(base);
        fork
            feed(base, 0, 48, 0);
            for (int rc = 0; rc < 270; rc++) begin
                e = model(rc, 3, t0s, wb);
                ir = !(rc == 32 || (rc >= 49 && rc <= 112));
                got  = {phase_advance7, load6, a_valid, busy, in_ready};
                want = {e.pa, e.ld, e.av, e.busy, ir};
                n_checks++; if (got !== want) begin n_fail++; $display("FAIL bp_ctrl rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                if (e.dv) begin n_checks++; if (din !== e.dw) begin n_fail++; $display("FAIL bp_din rc=%0d got %h want %h", rc, din, e.dw); end end
                if (e.av) begin n_checks++; if (a_word !== e.aw) begin n_fail++; $display("FAIL bp_a_word rc=%0d got %0d want %0d", rc, a_word, e.aw); end end
                @(posedge clk); #1;
            end
        join
        n_checks++; if (acc_cyc[31] !== 31) begin n_fail++; $display("FAIL bp_acc31 got %0d want 31", acc_cyc[31]); end
        n_checks++; if (acc_cyc[32] !== 33) begin n_fail++; $display("FAIL bp_acc32 got %0d want 33", acc_cyc[32]); end
        n_checks++; if (acc_cyc[47] !== 48) begin n_fail++; $display("FAIL bp_acc47 got %0d want 48", acc_cyc[47]); end
`ifdef SHA1_SCHED_PERF_EN
        n_checks++; if (perf_blocks !== 32'd3) begin n_fail++; $display("FAIL perf_blocks got %0d want 3", perf_blocks); end
        n_checks++; if (perf_idle !== 32'd15) begin n_fail++; $display("FAIL perf_idle got %0d want 15", perf_idle); end
`endif
    endtask

    task automatic test_late_fill();
        int base;
        int t0s[3];
        int wb[3];
        exp_t e;
        logic [4:0] got, want;
        t0s = '{17, 98, 0};
        wb  = '{0, 16, 0};
        apply_reset(base);
        fork
            begin
                feed(base, 0, 16, 0);
                feed(base, 16, 16, 81);
            end
            for (int rc = 0; rc < 190; rc++) begin
                e = model(rc, 2, t0s, wb);
                got  = {phase_advance7, load6, a_valid, busy, in_ready};
                want = {e.pa, e.ld, e.av, e.busy, 1'b1};
                n_checks++; if (got !== want) begin n_fail++; $display("FAIL late_ctrl rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                if (e.dv) begin n_checks++; if (din !== e.dw) begin n_fail++; $display("FAIL late_din rc=%0d got %h want %h", rc, din, e.dw); end end
                @(posedge clk); #1;
            end
        join
        n_checks++; if (acc_cyc[31] !== 96) begin n_fail++; $display("FAIL late_acc31 got %0d want 96", acc_cyc[31]); end
    endtask

    task automatic test_reset_mid();
        int base;
        int t0s[3];
        int wb[3];
        exp_t e;
        logic [4:0] got, want;
        t0s = '{17, 0, 0};
        wb  = '{0, 0, 0};
        apply_reset(base);
        fork
            feed(base, 0, 24, 0);
            begin
                for (int rc = 0; rc < 58; rc++) begin
                    e = model(rc, 1, t0s, wb);
                    got  = {phase_advance7, load6, a_valid, busy, in_ready};
                    want = {e.pa, e.ld, e.av, e.busy, 1'b1};
                    n_checks++; if (got !== want) begin n_fail++; $display("FAIL rmid_pre rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                    if (rc == 57) rst_n = 1'b0;
                    @(posedge clk); #1;
                end
                rst_n = 1'b1;
                for (int rc = 58; rc < 170; rc++) begin
                    got = {phase_advance7, load6, a_valid, busy, in_ready};
                    n_checks++; if (got !== 5'b00001) begin n_fail++; $display("FAIL rmid_quiet rc=%0d got %b want 00001 (pa,ld,av,busy,rdy)", rc, got); end
                    @(posedge clk); #1;
                end
            end
        join
        base = cyc;
        wb = '{100, 0, 0};
        fork
            feed(base, 100, 16, 0);
            for (int rc = 0; rc < 110; rc++) begin
                e = model(rc, 1, t0s, wb);
                got  = {phase_advance7, load6, a_valid, busy, in_ready};
                want = {e.pa, e.ld, e.av, e.busy, 1'b1};
                n_checks++; if (got !== want) begin n_fail++; $display("FAIL rmid_post rc=%0d got %b want %b (pa,ld,av,busy,rdy)", rc, got, want); end
                if (e.dv) begin n_checks++; if (din !== e.dw) begin n_fail++; $display("FAIL rmid_din rc=%0d got %h want %h", rc, din, e.dw); end end
                if (e.av) begin n_checks++; if (a_word !== e.aw) begin n_fail++; $display("FAIL rmid_a_word rc=%0d got %0d want %0d", rc, a_word, e.aw); end end
                @(posedge clk); #1;
            end
        join
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_late_fill();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
